// File: rtl/wb_serial_master_bridge.sv
// Byte-stream to Wishbone classic bridge: cmd + 4 addr (+4 data) bytes in, one bus cycle, 1 or 4 response bytes out.
// Latency: bus cycle starts the cycle after the last frame byte; first response byte is visible the cycle after ack.
// Backpressure: rx_ready low outside IDLE/ADDR/DATA, so pending bytes wait; tx_valid/tx_data are held until tx_ready.
// Optional bus timeout with 0xEE error response: define WB_BRIDGE_TIMEOUT_EN.
module wb_serial_master_bridge #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 11
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,
    input  logic [31:0] wb_dat_i,
    output logic        busy
);

    // The timeout counter must be able to represent TIMEOUT_CYCLES.
    if ((2 ** CNT_W) <= TIMEOUT_CYCLES) begin : g_bad_cnt_w
        $error("CNT_W too narrow for TIMEOUT_CYCLES");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_BUS,
        ST_RESP
    } state_t;

    localparam logic [7:0] RESP_WR_OK  = 8'hA5;
    localparam logic [7:0] RESP_TMO    = 8'hEE;

    state_t      state_q, state_nxt;
    logic        we_q, we_nxt;
    logic [1:0]  byte_cnt_q, byte_cnt_nxt;
    logic [31:0] rdat_q, rdat_nxt;       // remaining read bytes, next one in [31:24]
    logic [1:0]  resp_left_q, resp_left_nxt;

    logic [31:0] adr_nxt, dat_nxt;
    logic [3:0]  sel_nxt;
    logic [7:0]  tx_data_nxt;
    logic        rx_acc, tx_acc;

`ifdef WB_BRIDGE_TIMEOUT_EN
    logic [CNT_W-1:0] tmo_q, tmo_nxt;
`endif

    // Next-state and next-value logic for every registered output.
    always_comb begin
        state_nxt     = state_q;
        we_nxt        = we_q;
        byte_cnt_nxt  = byte_cnt_q;
        rdat_nxt      = rdat_q;
        resp_left_nxt = resp_left_q;
        adr_nxt       = wb_adr_o;
        dat_nxt       = wb_dat_o;
        sel_nxt       = wb_sel_o;
        tx_data_nxt   = tx_data;
        rx_acc        = rx_valid && rx_ready;
        tx_acc        = tx_valid && tx_ready;
`ifdef WB_BRIDGE_TIMEOUT_EN
        tmo_nxt       = tmo_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // Reserved bits set: the byte is swallowed and we stay put.
                if (rx_acc && (rx_data[6:4] == 3'b000)) begin
                    we_nxt       = rx_data[7];
                    sel_nxt      = rx_data[3:0];
                    byte_cnt_nxt = 2'd0;
                    state_nxt    = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (rx_acc) begin
                    adr_nxt      = {wb_adr_o[23:0], rx_data};
                    byte_cnt_nxt = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_nxt = we_q ? ST_DATA : ST_BUS;
                    end
                end
            end
            ST_DATA: begin
                if (rx_acc) begin
                    dat_nxt      = {wb_dat_o[23:0], rx_data};
                    byte_cnt_nxt = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_nxt = ST_BUS;
                    end
                end
            end
            ST_BUS: begin
                // Ack wins over a timeout that expires in the same cycle.
                if (wb_ack_i) begin
                    state_nxt = ST_RESP;
                    if (we_q) begin
                        tx_data_nxt   = RESP_WR_OK;
                        resp_left_nxt = 2'd0;
                    end else begin
                        tx_data_nxt   = wb_dat_i[31:24];
                        rdat_nxt      = {wb_dat_i[23:0], 8'h00};
                        resp_left_nxt = 2'd3;
                    end
                end
`ifdef WB_BRIDGE_TIMEOUT_EN
                else if (tmo_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_nxt     = ST_RESP;
                    tx_data_nxt   = RESP_TMO;
                    resp_left_nxt = 2'd0;
                end else begin
                    tmo_nxt = tmo_q + CNT_W'(1);
                end
`endif
            end
            ST_RESP: begin
                if (tx_acc) begin
                    if (resp_left_q == 2'd0) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        tx_data_nxt   = rdat_q[31:24];
                        rdat_nxt      = {rdat_q[23:0], 8'h00};
                        resp_left_nxt = resp_left_q - 2'd1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
`ifdef WB_BRIDGE_TIMEOUT_EN
        // Every bus cycle starts with a fresh timeout budget.
        if ((state_nxt == ST_BUS) && (state_q != ST_BUS)) begin
            tmo_nxt = '0;
        end
`endif
    end

    // State and output registers; outputs are derived from the next state so they are glitch-free.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            byte_cnt_q  <= 2'd0;
            rdat_q      <= 32'h0;
            resp_left_q <= 2'd0;
            wb_adr_o    <= 32'h0;
            wb_dat_o    <= 32'h0;
            wb_sel_o    <= 4'h0;
            wb_we_o     <= 1'b0;
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            tx_data     <= 8'h0;
            tx_valid    <= 1'b0;
            rx_ready    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            we_q        <= we_nxt;
            byte_cnt_q  <= byte_cnt_nxt;
            rdat_q      <= rdat_nxt;
            resp_left_q <= resp_left_nxt;
            wb_adr_o    <= adr_nxt;
            wb_dat_o    <= dat_nxt;
            wb_sel_o    <= sel_nxt;
            wb_we_o     <= (state_nxt == ST_BUS) && we_q;
            wb_cyc_o    <= (state_nxt == ST_BUS);
            wb_stb_o    <= (state_nxt == ST_BUS);
            tx_data     <= tx_data_nxt;
            tx_valid    <= (state_nxt == ST_RESP);
            rx_ready    <= (state_nxt == ST_IDLE) || (state_nxt == ST_ADDR) || (state_nxt == ST_DATA);
            busy        <= (state_nxt != ST_IDLE);
        end
    end

`ifdef WB_BRIDGE_TIMEOUT_EN
    // Bus timeout counter.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_wb_serial_master_bridge.sv
// Bench for wb_serial_master_bridge: directed frames plus randomized frames/waits/backpressure.
// Expected bus transactions and response bytes come from a frame-level model built with queues.
// Slave and tx sink run as independent processes driving on the falling edge.
`timescale 1ns/1ps
module tb_wb_serial_master_bridge;

    localparam int TMO   = 16;
    localparam int LIMIT = 2000;

    logic        clk = 1'b0;
    logic        wb_rst_i = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i;
    logic        busy;

    always #5 clk = ~clk;

    wb_serial_master_bridge #(.TIMEOUT_CYCLES(TMO), .CNT_W(11)) dut (
        .wb_clk_i(clk), .wb_rst_i(wb_rst_i),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i), .busy(busy)
    );

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
        logic        aborted;
        logic [7:0]  len;
    } txn_t;

    txn_t        obs_bus_q[$], exp_bus_q[$];
    logic [7:0]  obs_tx_q[$], exp_tx_q[$];
    int          plan_wait_q[$];
    logic [31:0] plan_rdat_q[$];

    int n_total = 0;
    int n_bad   = 0;
    int bp_mode = 0;      // 0: always ready, 1: random, 2: 5 stall cycles per byte
    bit slave_mute = 1'b0;
    bit stray_ack  = 1'b0;
    bit stuck      = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Wishbone slave: per-transaction wait count and read data come from the plan queues.
    initial begin : slave
        int          bus_len;
        int          wait_tgt;
        logic [31:0] rd;
        txn_t        t;
        bus_len  = 0;
        wait_tgt = 0;
        rd       = 32'h0;
        t        = '0;
        wb_ack_i = 1'b0;
        wb_dat_i = 32'h0;
        forever begin
            @(negedge clk);
            wb_ack_i = 1'b0;
            if (wb_cyc_o && wb_stb_o) begin
                if (bus_len == 0) begin
                    t     = '0;
                    t.adr = wb_adr_o;
                    t.dat = wb_dat_o;
                    t.sel = wb_sel_o;
                    t.we  = wb_we_o;
                    if (plan_wait_q.size() > 0) begin
                        wait_tgt = plan_wait_q.pop_front();
                        rd       = plan_rdat_q.pop_front();
                    end else begin
                        wait_tgt = 0;
                        rd       = 32'hBAD0_0000;
                    end
                end else begin
                    check_eq("adr_hold", wb_adr_o, t.adr);
                    check_eq("we_hold", wb_we_o, t.we);
                end
                check_eq("busy_in_bus", busy, 1'b1);
                check_eq("rx_ready_in_bus", rx_ready, 1'b0);
                bus_len++;
                if (!slave_mute && bus_len > wait_tgt) begin
                    wb_ack_i = 1'b1;
                    wb_dat_i = rd;
                    t.len    = 8'(bus_len);
                    obs_bus_q.push_back(t);
                    bus_len  = 0;
                end
            end else begin
                if (bus_len != 0 && wb_rst_i) begin
                    t.len     = 8'(bus_len);
                    t.aborted = 1'b1;
                    obs_bus_q.push_back(t);
                end
                bus_len = 0;
                if (stray_ack) wb_ack_i = ($urandom_range(0, 3) == 0);
            end
        end
    end

    // Response sink with configurable backpressure and hold-stability checks.
    initial begin : tx_sink
        int         hold;
        logic       was_stalled;
        logic [7:0] stall_dat;
        hold        = 0;
        was_stalled = 1'b0;
        stall_dat   = 8'h0;
        tx_ready    = 1'b0;
        forever begin
            @(negedge clk);
            if (was_stalled) begin
                check_eq("tx_valid_hold", tx_valid, 1'b1);
                check_eq("tx_data_hold", tx_data, stall_dat);
            end
            case (bp_mode)
                0: tx_ready = 1'b1;
                1: tx_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (tx_valid && hold < 5) begin
                        tx_ready = 1'b0;
                        hold++;
                    end else begin
                        tx_ready = 1'b1;
                    end
                end
            endcase
            if (tx_valid) check_eq("rx_ready_in_resp", rx_ready, 1'b0);
            if (tx_valid && tx_ready) begin
                obs_tx_q.push_back(tx_data);
                hold = 0;
            end
            was_stalled = tx_valid && !tx_ready;
            stall_dat   = tx_data;
        end
    end

    // Offer one byte (called on a falling edge, returns on a falling edge after acceptance).
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        if (stuck) return;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) begin
            check_eq("rx_accept_timeout", rx_ready, 1'b1);
            stuck    = 1'b1;
            rx_valid = 1'b0;
            return;
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic gap(input int gap_max);
        repeat ($urandom_range(0, gap_max)) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [31:0] adr,
                              input logic [31:0] dat, input int gap_max);
        send_byte(cmd);
        if (cmd[6:4] != 3'b000) return;
        for (int i = 3; i >= 0; i--) begin
            gap(gap_max);
            send_byte(adr[8*i +: 8]);
        end
        if (cmd[7]) begin
            for (int i = 3; i >= 0; i--) begin
                gap(gap_max);
                send_byte(dat[8*i +: 8]);
            end
        end
    endtask

    // Frame-level reference: what the bus should see and what bytes come back.
    task automatic model_frame(input logic [7:0] cmd, input logic [31:0] adr, input logic [31:0] dat,
                               input int wait_cycles, input logic [31:0] rdat, input bit timeout);
        txn_t e;
        if (cmd[6:4] != 3'b000) return;
        plan_wait_q.push_back(wait_cycles);
        plan_rdat_q.push_back(rdat);
        e         = '0;
        e.adr     = adr;
        e.dat     = dat;
        e.sel     = cmd[3:0];
        e.we      = cmd[7];
        e.aborted = timeout;
        e.len     = timeout ? 8'(TMO) : 8'(wait_cycles + 1);
        exp_bus_q.push_back(e);
        if (timeout) begin
            exp_tx_q.push_back(8'hEE);
        end else if (cmd[7]) begin
            exp_tx_q.push_back(8'hA5);
        end else begin
            for (int i = 3; i >= 0; i--) exp_tx_q.push_back(rdat[8*i +: 8]);
        end
    endtask

    task automatic drain_and_compare();
        int   n;
        txn_t o, e;
        n = 0;
        while ((obs_bus_q.size() < exp_bus_q.size() || obs_tx_q.size() < exp_tx_q.size() || busy)
               && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check_eq("bus_count", obs_bus_q.size(), exp_bus_q.size());
        check_eq("tx_count", obs_tx_q.size(), exp_tx_q.size());
        while (obs_bus_q.size() > 0 && exp_bus_q.size() > 0) begin
            o = obs_bus_q.pop_front();
            e = exp_bus_q.pop_front();
            check_eq("bus_adr", o.adr, e.adr);
            check_eq("bus_sel", o.sel, e.sel);
            check_eq("bus_we", o.we, e.we);
            check_eq("bus_aborted", o.aborted, e.aborted);
            check_eq("bus_len", o.len, e.len);
            if (e.we) check_eq("bus_wdat", o.dat, e.dat);
        end
        while (obs_tx_q.size() > 0 && exp_tx_q.size() > 0) begin
            check_eq("tx_byte", obs_tx_q.pop_front(), exp_tx_q.pop_front());
        end
        obs_bus_q.delete();
        exp_bus_q.delete();
        obs_tx_q.delete();
        exp_tx_q.delete();
        plan_wait_q.delete();
        plan_rdat_q.delete();
    endtask

    initial begin : watchdog
        #900_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int          n;
        logic [7:0]  cmd;
        logic [31:0] adr, dat, rd;
        int          w;
        rx_data  = 8'h0;
        rx_valid = 1'b0;

        // Reset values
        #1;
        check_eq("rst_cyc", wb_cyc_o, 1'b0);
        check_eq("rst_stb", wb_stb_o, 1'b0);
        check_eq("rst_we", wb_we_o, 1'b0);
        check_eq("rst_adr", wb_adr_o, 32'h0);
        check_eq("rst_dat", wb_dat_o, 32'h0);
        check_eq("rst_sel", wb_sel_o, 4'h0);
        check_eq("rst_tx_valid", tx_valid, 1'b0);
        check_eq("rst_tx_data", tx_data, 8'h0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_rx_ready", rx_ready, 1'b0);
        @(negedge clk);
        @(negedge clk);
        wb_rst_i = 1'b1;
        #1 check_eq("rel_rx_ready_pre_edge", rx_ready, 1'b0);
        @(negedge clk);
        check_eq("rel_rx_ready", rx_ready, 1'b1);
        check_eq("rel_busy", busy, 1'b0);

        // Write with two wait states
        bp_mode = 0;
        model_frame(8'h8F, 32'h3000_0004, 32'hDEAD_BEEF, 2, 32'h0, 1'b0);
        send_frame(8'h8F, 32'h3000_0004, 32'hDEAD_BEEF, 0);
        drain_and_compare();

        // Read, zero-wait, heavy tx backpressure
        bp_mode = 2;
        model_frame(8'h0F, 32'h3080_0008, 32'h0, 0, 32'h1234_5678, 1'b0);
        send_frame(8'h0F, 32'h3080_0008, 32'h0, 0);
        drain_and_compare();
        bp_mode = 0;

        // Reserved command is dropped, following read is normal
        send_frame(8'h10, 32'h0, 32'h0, 0);
        check_eq("busy_after_rsvd", busy, 1'b0);
        check_eq("rx_ready_after_rsvd", rx_ready, 1'b1);
        model_frame(8'h03, 32'h3000_0100, 32'h0, 1, 32'hCAFE_F00D, 1'b0);
        send_frame(8'h03, 32'h3000_0100, 32'h0, 1);
        drain_and_compare();

        // Reset during a bus cycle
        plan_wait_q.push_back(50);
        plan_rdat_q.push_back(32'h0);
        send_frame(8'h8F, 32'h3000_0010, 32'h1111_2222, 0);
        n = 0;
        while (!wb_cyc_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("cyc_before_rst", wb_cyc_o, 1'b1);
        #2 wb_rst_i = 1'b0;
        #1;
        check_eq("midrst_cyc", wb_cyc_o, 1'b0);
        check_eq("midrst_stb", wb_stb_o, 1'b0);
        check_eq("midrst_busy", busy, 1'b0);
        check_eq("midrst_we", wb_we_o, 1'b0);
        @(negedge clk);
        wb_rst_i = 1'b1;
        @(negedge clk);
        check_eq("post_rst_rx_ready", rx_ready, 1'b1);
        drain_and_compare();
        model_frame(8'h85, 32'h3000_0020, 32'h0BAD_F00D, 1, 32'h0, 1'b0);
        send_frame(8'h85, 32'h3000_0020, 32'h0BAD_F00D, 0);
        drain_and_compare();

        // Randomized frames, back to back, with stray acks and random backpressure
        bp_mode   = 1;
        stray_ack = 1'b1;
        for (int k = 0; k < 40; k++) begin
            cmd = 8'($urandom);
            if ($urandom_range(0, 9) != 0) cmd[6:4] = 3'b000;
            adr = $urandom;
            dat = $urandom;
            rd  = $urandom;
            w   = $urandom_range(0, 4);
            model_frame(cmd, adr, dat, w, rd, 1'b0);
            send_frame(cmd, adr, dat, 2);
        end
        drain_and_compare();
        stray_ack = 1'b0;
        bp_mode   = 0;

`ifdef WB_BRIDGE_TIMEOUT_EN
        // Read against a silent slave
        slave_mute = 1'b1;
        model_frame(8'h0F, 32'h3000_0040, 32'h0, 0, 32'h0, 1'b1);
        send_frame(8'h0F, 32'h3000_0040, 32'h0, 0);
        drain_and_compare();
        check_eq("tmo_idle_rx_ready", rx_ready, 1'b1);
        slave_mute = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
